block_scroller: RTL and testbench
=================================

# block_scroller

Falling-block engine for the piano-block game. It walks the song note address, and the lane-pattern stage turns that address into an 8-bit lane-enable word. This block registers that word into a LANES×ROWS block grid, scrolls the grid down one row per beat tick, and judges player key presses against the bottom (hit) row. It also drives the flattened grid to the VGA renderer and the score/miss counters to the seven-segment display.

## Interface
- LANES, 8, number of lanes (width of lane-enable word and key bus)
- ROWS, 16, grid depth; row 0 = top (spawn), row ROWS-1 = bottom (hit row)
- TICK_DIV, 10_000_000, clk cycles per scroll step (0.1 s at 100 MHz)
- SONG_LEN, 128, number of note addresses played (1..128)
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a game from IDLE or DONE
- pause  in  1  level; while high in RUN, scrolling and judging freeze
- key  in  LANES  debounced key levels, one per lane
- v_enb  in  LANES  lane-enable word for current addr (combinational from lane-pattern stage)
- addr  out  7  current note address to lane-pattern stage
- grid  out  LANES*ROWS  block map; bit r*LANES+l = row r, lane l
- score  out  10  hit count, saturating at 1023
- miss_cnt  out  10  missed-block count, saturating at 1023
- wrong_cnt  out  10  presses on empty hit-row lanes, saturating at 1023
- hit_pulse  out  1  one-cycle pulse per cycle with ≥1 hit
- miss_pulse  out  1  one-cycle pulse per step with ≥1 miss
- done  out  1  high in DONE state

## Operation
- States: IDLE → RUN on start; RUN ↔ PAUSE on pause level; RUN → DONE when all notes spawned and grid empty; DONE → RUN on start (fresh game); any state → IDLE on rst.
- Entering RUN from start clears grid, addr, note counter (8-bit, internal), tick counter, score, miss_cnt, wrong_cnt.
- Tick counter counts 0..TICK_DIV-1 in RUN only (held in PAUSE); step asserted the cycle it equals TICK_DIV-1, then wraps to 0.
- On step: misses = popcount of row ROWS-1 after this cycle's hits are cleared; all rows shift down by one; row 0 loads v_enb if note counter < SONG_LEN, else zero; note counter increments (saturates at SONG_LEN); addr = note counter[6:0].
- Key judging (RUN only): rising edge on key[l] (registered previous key vs current) with grid row ROWS-1 lane l set → clear bit, score+1; with bit clear → wrong_cnt+1. Multiple lanes same cycle each count.
- Simultaneous hit and step on same lane: hit wins; counted as hit, not miss.
- Key edges during PAUSE, IDLE, DONE are ignored; previous-key register still tracks key so release/press across pause produces no stale edge.
- Counters add the per-cycle count then saturate at 1023 (no wrap).
- DONE condition checked every RUN cycle: note counter == SONG_LEN and grid all zero.

## Timing
- Reset values: addr 0, grid 0, score 0, miss_cnt 0, wrong_cnt 0, hit_pulse 0, miss_pulse 0, done 0, state IDLE.
- v_enb sampled on the step edge using the registered addr; addr updates the same edge, so v_enb has one full step period to settle.
- First step after start occurs TICK_DIV cycles after start and loads addr 0's pattern into row 0.
- A spawned block reaches row ROWS-1 after ROWS-1 further steps; it is judged for one step period, then counted as missed on the next step.
- hit_pulse one cycle after the judging edge; miss_pulse coincident with the register update of the step; done rises the cycle after the grid empties.
- rst mid-game: all outputs return to reset values next edge; start is required to resume.

## Structure
- Shared package: state encoding (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE), counter width (10), and saturation limit 1023, shared with the display blocks.
- One sub-module, lane_popcount (LANES-bit popcount), used for hit and miss counts.

## Test plan
- TICK_DIV=4, ROWS=4, SONG_LEN=8; bench drives v_enb from the lane-pattern model (addr%8 → 01,10,44,28,04,22,80,01). Tests:
- Reset then start: first step at cycle 4 puts 8'h01 in row 0 and sets addr to 1; after 4 steps row 3 = 8'h01.
- No keys for the whole song: miss_cnt = 11 (popcounts 1+1+2+2+1+2+1+1), score 0, done high once grid is empty.
- Press key[0] while row 3 = 8'h01, on the same cycle as a step: score = 1, miss_cnt unchanged, hit_pulse one cycle.
- Press key[7] while row 3 lane 7 is clear: wrong_cnt = 1, grid unchanged.
- pause held 20 cycles mid-song: grid, addr, and tick counter frozen; key presses ignored; resume continues the step cadence exactly.
- rst asserted mid-song: next cycle all outputs 0 and state IDLE; start restarts from addr 0.

Source files
------------

// File: rtl/block_scroller_pkg.sv
// Shared definitions for the falling-block engine and the score display blocks.
package block_scroller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned     CNT_W   = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = 10'd1023;

    // Add an increment to a counter and clamp at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, CNT_MAX}) begin
            sat_add = CNT_MAX;
        end else begin
            sat_add = sum[CNT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/block_scroller_lane_popcount.sv
// Counts the set bits of a lane word; used for hit, wrong-press and miss tallies.
module lane_popcount #(
    parameter int unsigned LANES = 8
) (
    input  logic [LANES-1:0]            bits,
    output logic [$clog2(LANES+1)-1:0]  count
);

    // Ripple sum of the individual lane bits.
    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            count = count + ($clog2(LANES+1))'(bits[i]);
        end
    end

endmodule

// File: rtl/block_scroller.sv
// Falling-block engine: spawns lane patterns into a block grid, scrolls it one
// row per beat tick and judges key presses against the bottom (hit) row.
module block_scroller
    import block_scroller_pkg::*;
#(
    parameter int unsigned LANES    = 8,
    parameter int unsigned ROWS     = 16,
    parameter int unsigned TICK_DIV = 10_000_000,
    parameter int unsigned SONG_LEN = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   pause,
    input  logic [LANES-1:0]       key,
    input  logic [LANES-1:0]       v_enb,
    output logic [6:0]             addr,
    output logic [LANES*ROWS-1:0]  grid,
    output logic [CNT_W-1:0]       score,
    output logic [CNT_W-1:0]       miss_cnt,
    output logic [CNT_W-1:0]       wrong_cnt,
    output logic                   hit_pulse,
    output logic                   miss_pulse,
    output logic                   done
);

    localparam int unsigned       GW        = LANES * ROWS;
    localparam int unsigned       BOT       = (ROWS - 1) * LANES;
    localparam int unsigned       PC_W      = $clog2(LANES + 1);
    localparam int unsigned       TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [7:0]        SONG_END  = 8'(SONG_LEN);

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [7:0]         note_q, note_d;
    logic [GW-1:0]      grid_q, grid_d;
    logic [CNT_W-1:0]   score_q, score_d;
    logic [CNT_W-1:0]   miss_q, miss_d;
    logic [CNT_W-1:0]   wrong_q, wrong_d;
    logic [LANES-1:0]   key_prev_q, key_prev_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic               miss_pulse_q, miss_pulse_d;

    logic               clear;
    logic               active;
    logic               step;
    logic               note_lt;
    logic [LANES-1:0]   key_rise;
    logic [LANES-1:0]   hit_row;
    logic [LANES-1:0]   hits;
    logic [LANES-1:0]   wrongs;
    logic [LANES-1:0]   bottom_after;
    logic [LANES-1:0]   row0_in;
    logic [GW-1:0]      grid_hc;
    logic [PC_W-1:0]    hit_n;
    logic [PC_W-1:0]    wrong_n;
    logic [PC_W-1:0]    miss_n;

    lane_popcount #(.LANES(LANES)) u_hit_pc   (.bits(hits),         .count(hit_n));
    lane_popcount #(.LANES(LANES)) u_wrong_pc (.bits(wrongs),       .count(wrong_n));
    lane_popcount #(.LANES(LANES)) u_miss_pc  (.bits(bottom_after), .count(miss_n));

    // Game-state sequencing; a start pulse from IDLE or DONE launches a fresh game.
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                end
            end
            ST_RUN: begin
                if (note_q == SONG_END && grid_q == '0) begin
                    state_d = ST_DONE;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Key-edge judging against the hit row; hits are removed before the miss count.
    always_comb begin
        active       = (state_q == ST_RUN) && !pause;
        step         = active && (tick_q == TICK_LAST);
        note_lt      = (note_q < SONG_END);
        key_rise     = key & ~key_prev_q;
        hit_row      = grid_q[BOT +: LANES];
        hits         = active ? (key_rise & hit_row)  : '0;
        wrongs       = active ? (key_rise & ~hit_row) : '0;
        bottom_after = hit_row & ~hits;
        row0_in      = note_lt ? v_enb : '0;
        grid_hc      = grid_q;
        grid_hc[BOT +: LANES] = bottom_after;
    end

    // Next-state datapath: scroll on step, accumulate saturating counters.
    always_comb begin
        tick_d       = tick_q;
        note_d       = note_q;
        grid_d       = grid_q;
        score_d      = score_q;
        miss_d       = miss_q;
        wrong_d      = wrong_q;
        key_prev_d   = key;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        if (clear) begin
            tick_d  = '0;
            note_d  = '0;
            grid_d  = '0;
            score_d = '0;
            miss_d  = '0;
            wrong_d = '0;
        end else if (active) begin
            grid_d      = grid_hc;
            score_d     = sat_add(score_q, CNT_W'(hit_n));
            wrong_d     = sat_add(wrong_q, CNT_W'(wrong_n));
            hit_pulse_d = (hit_n != '0);
            if (step) begin
                tick_d       = '0;
                grid_d       = {grid_hc[GW-LANES-1:0], row0_in};
                note_d       = note_lt ? note_q + 8'd1 : note_q;
                miss_d       = sat_add(miss_q, CNT_W'(miss_n));
                miss_pulse_d = (miss_n != '0);
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            note_q       <= '0;
            grid_q       <= '0;
            score_q      <= '0;
            miss_q       <= '0;
            wrong_q      <= '0;
            key_prev_q   <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            note_q       <= note_d;
            grid_q       <= grid_d;
            score_q      <= score_d;
            miss_q       <= miss_d;
            wrong_q      <= wrong_d;
            key_prev_q   <= key_prev_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
        end
    end

    assign addr       = note_q[6:0];
    assign grid       = grid_q;
    assign score      = score_q;
    assign miss_cnt   = miss_q;
    assign wrong_cnt  = wrong_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_block_scroller.sv
// Scoreboard bench for block_scroller: stimulus pushes expected values, a
// negedge monitor pops and compares them as the DUT presents results.
module tb_block_scroller;
    import block_scroller_pkg::*;

    localparam int unsigned LANES    = 8;
    localparam int unsigned ROWS     = 4;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned SONG_LEN = 8;
    localparam int unsigned GW       = LANES * ROWS;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             pause;
    logic [LANES-1:0] key;
    logic [LANES-1:0] v_enb;
    logic [6:0]       addr;
    logic [GW-1:0]    grid;
    logic [CNT_W-1:0] score;
    logic [CNT_W-1:0] miss_cnt;
    logic [CNT_W-1:0] wrong_cnt;
    logic             hit_pulse;
    logic             miss_pulse;
    logic             done;

    block_scroller #(
        .LANES(LANES), .ROWS(ROWS), .TICK_DIV(TICK_DIV), .SONG_LEN(SONG_LEN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .key(key),
        .v_enb(v_enb), .addr(addr), .grid(grid), .score(score),
        .miss_cnt(miss_cnt), .wrong_cnt(wrong_cnt), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .done(done)
    );

    always #5 clk = ~clk;

    // Lane-pattern stage model.
    function automatic logic [7:0] pattern(input logic [6:0] a);
        case (a[2:0])
            3'd0: pattern = 8'h01;
            3'd1: pattern = 8'h10;
            3'd2: pattern = 8'h44;
            3'd3: pattern = 8'h28;
            3'd4: pattern = 8'h04;
            3'd5: pattern = 8'h22;
            3'd6: pattern = 8'h80;
            default: pattern = 8'h01;
        endcase
    endfunction

    always_comb v_enb = pattern(addr);

    // Edge counter: at a negedge, cyc equals the number of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {SEL_ADDR, SEL_GRID, SEL_SCORE, SEL_MISS, SEL_WRONG,
                      SEL_DONE, SEL_HITP, SEL_MISSP} sel_t;
    typedef struct {
        int          at;
        sel_t        sel;
        logic [31:0] exp;
        string       name;
    } chk_t;
    typedef struct {
        int          at;
        logic [31:0] cnt;
    } mp_t;

    chk_t exp_q[$];
    int   hit_q[$];
    mp_t  miss_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_chk(input int at, input sel_t sel, input logic [31:0] exp, input string name);
        chk_t c;
        int   idx;
        c.at = at; c.sel = sel; c.exp = exp; c.name = name;
        idx = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].at > at) begin
                idx = i;
                break;
            end
        end
        exp_q.insert(idx, c);
    endtask

    task automatic push_miss(input int at, input int cnt);
        mp_t m;
        m.at = at; m.cnt = cnt;
        miss_q.push_back(m);
    endtask

    task automatic push_all_zero(input int at, input string tag);
        push_chk(at, SEL_ADDR,  0, {tag, "_addr"});
        push_chk(at, SEL_GRID,  0, {tag, "_grid"});
        push_chk(at, SEL_SCORE, 0, {tag, "_score"});
        push_chk(at, SEL_MISS,  0, {tag, "_miss"});
        push_chk(at, SEL_WRONG, 0, {tag, "_wrong"});
        push_chk(at, SEL_DONE,  0, {tag, "_done"});
        push_chk(at, SEL_HITP,  0, {tag, "_hitp"});
        push_chk(at, SEL_MISSP, 0, {tag, "_missp"});
    endtask

    function automatic logic [31:0] observe(input sel_t s);
        case (s)
            SEL_ADDR:  observe = {25'd0, addr};
            SEL_GRID:  observe = grid;
            SEL_SCORE: observe = {22'd0, score};
            SEL_MISS:  observe = {22'd0, miss_cnt};
            SEL_WRONG: observe = {22'd0, wrong_cnt};
            SEL_DONE:  observe = {31'd0, done};
            SEL_HITP:  observe = {31'd0, hit_pulse};
            default:   observe = {31'd0, miss_pulse};
        endcase
    endfunction

    task automatic goto(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    // Monitor: scheduled checks plus pulse-driven checks for hit/miss events.
    always @(negedge clk) begin : monitor
        chk_t c;
        mp_t  m;
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            c = exp_q.pop_front();
            if (c.at < cyc) compare({c.name, "_late"}, cyc, c.at);
            else            compare(c.name, observe(c.sel), c.exp);
        end
        if (hit_pulse === 1'b1) begin
            if (hit_q.size() > 0) compare("hit_pulse_cycle", cyc, hit_q.pop_front());
            else                  compare("hit_pulse_unexpected", {31'd0, hit_pulse}, 0);
        end
        if (miss_pulse === 1'b1) begin
            if (miss_q.size() > 0) begin
                m = miss_q.pop_front();
                compare("miss_pulse_cycle", cyc, m.at);
                compare("miss_pulse_cnt", {22'd0, miss_cnt}, m.cnt);
            end else begin
                compare("miss_pulse_unexpected", {31'd0, miss_pulse}, 0);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout @cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    int e0, e1, e2;

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; key = '0;
        push_all_zero(2, "reset");
        goto(3);
        rst = 1'b0;

        // Game 1: no keys, every block is missed.
        goto(5);
        e0 = cyc + 1;
        push_chk(e0 + 3,  SEL_ADDR, 0,            "g1_pre_step_addr");
        push_chk(e0 + 3,  SEL_GRID, 0,            "g1_pre_step_grid");
        push_chk(e0 + 4,  SEL_ADDR, 1,            "g1_step1_addr");
        push_chk(e0 + 4,  SEL_GRID, 32'h00000001, "g1_step1_grid");
        push_chk(e0 + 16, SEL_ADDR, 4,            "g1_step4_addr");
        push_chk(e0 + 16, SEL_GRID, 32'h01104428, "g1_step4_grid");
        push_miss(e0 + 20, 1);  push_miss(e0 + 24, 2);
        push_miss(e0 + 28, 4);  push_miss(e0 + 32, 6);
        push_miss(e0 + 36, 7);  push_miss(e0 + 40, 9);
        push_miss(e0 + 44, 10); push_miss(e0 + 48, 11);
        push_chk(e0 + 48, SEL_DONE,  0,  "g1_done_low");
        push_chk(e0 + 49, SEL_DONE,  1,  "g1_done_high");
        push_chk(e0 + 49, SEL_MISS,  11, "g1_miss_total");
        push_chk(e0 + 49, SEL_SCORE, 0,  "g1_score");
        push_chk(e0 + 49, SEL_ADDR,  8,  "g1_addr_end");
        push_chk(e0 + 49, SEL_GRID,  0,  "g1_grid_empty");
        start = 1'b1;
        goto(e0);
        start = 1'b0;

        // Game 2: hits, wrong press, pause, mid-song reset.
        goto(e0 + 52);
        e1 = cyc + 1;
        push_chk(e1 + 1,  SEL_SCORE, 0, "g2_clr_score");
        push_chk(e1 + 1,  SEL_MISS,  0, "g2_clr_miss");
        push_chk(e1 + 1,  SEL_DONE,  0, "g2_clr_done");
        push_chk(e1 + 1,  SEL_ADDR,  0, "g2_clr_addr");
        push_chk(e1 + 1,  SEL_GRID,  0, "g2_clr_grid");
        hit_q.push_back(e1 + 20);
        hit_q.push_back(e1 + 26);
        push_miss(e1 + 24, 1); push_miss(e1 + 53, 3); push_miss(e1 + 57, 4);
        push_chk(e1 + 20, SEL_SCORE, 1,            "hit_on_step_score");
        push_chk(e1 + 20, SEL_MISS,  0,            "hit_on_step_miss");
        push_chk(e1 + 20, SEL_ADDR,  5,            "hit_on_step_addr");
        push_chk(e1 + 20, SEL_GRID,  32'h10442804, "hit_on_step_grid");
        push_chk(e1 + 22, SEL_WRONG, 1,            "wrong_cnt");
        push_chk(e1 + 22, SEL_GRID,  32'h10442804, "wrong_grid_kept");
        push_chk(e1 + 26, SEL_SCORE, 3,            "multi_hit_score");
        push_chk(e1 + 26, SEL_GRID,  32'h00280422, "multi_hit_grid");
        push_chk(e1 + 26, SEL_MISS,  1,            "multi_hit_miss");
        push_chk(e1 + 28, SEL_GRID,  32'h28042280, "step7_grid");
        push_chk(e1 + 28, SEL_ADDR,  7,            "step7_addr");
        push_chk(e1 + 40, SEL_GRID,  32'h28042280, "pause_grid");
        push_chk(e1 + 40, SEL_ADDR,  7,            "pause_addr");
        push_chk(e1 + 40, SEL_SCORE, 3,            "pause_score");
        push_chk(e1 + 40, SEL_WRONG, 1,            "pause_wrong");
        push_chk(e1 + 52, SEL_GRID,  32'h28042280, "resume_pre_grid");
        push_chk(e1 + 52, SEL_ADDR,  7,            "resume_pre_addr");
        push_chk(e1 + 53, SEL_ADDR,  8,            "resume_step_addr");
        push_chk(e1 + 53, SEL_GRID,  32'h04228001, "resume_step_grid");
        push_chk(e1 + 53, SEL_MISS,  3,            "resume_step_miss");
        push_chk(e1 + 53, SEL_SCORE, 3,            "resume_score");
        push_chk(e1 + 53, SEL_WRONG, 1,            "resume_wrong");
        push_chk(e1 + 57, SEL_GRID,  32'h22800100, "step9_grid");
        push_all_zero(e1 + 58, "midrst");
        push_chk(e1 + 62, SEL_ADDR, 0, "idle_addr");
        push_chk(e1 + 62, SEL_GRID, 0, "idle_grid");
        push_chk(e1 + 62, SEL_DONE, 0, "idle_done");
        start = 1'b1;
        goto(e1);
        start = 1'b0;

        goto(e1 + 19); key = 8'h01;
        goto(e1 + 21); key = 8'h81;
        goto(e1 + 22); key = 8'h00;
        goto(e1 + 25); key = 8'h44;
        goto(e1 + 26); key = 8'h00;
        goto(e1 + 29); pause = 1'b1;
        goto(e1 + 35); key = 8'h88;
        goto(e1 + 49); pause = 1'b0;
        goto(e1 + 56); key = 8'h00;
        goto(e1 + 57); rst = 1'b1;
        goto(e1 + 58); rst = 1'b0;

        // Restart after reset begins again from addr 0.
        goto(e1 + 63);
        e2 = cyc + 1;
        push_chk(e2 + 3, SEL_ADDR, 0,            "g3_pre_step_addr");
        push_chk(e2 + 3, SEL_GRID, 0,            "g3_pre_step_grid");
        push_chk(e2 + 4, SEL_ADDR, 1,            "g3_step1_addr");
        push_chk(e2 + 4, SEL_GRID, 32'h00000001, "g3_step1_grid");
        start = 1'b1;
        goto(e2);
        start = 1'b0;

        goto(e2 + 6);
        compare("exp_queue_drained",  exp_q.size(),  0);
        compare("hit_queue_drained",  hit_q.size(),  0);
        compare("miss_queue_drained", miss_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
